// File: rtl/booth_pkg.sv
// ============================================================================
// Module      : booth_pkg
// Description : Shared FSM state encoding and radix-4 Booth digit select bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit positions inside the 3-bit Booth digit {neg, one, two}
    localparam int unsigned c_dig_two = 0;
    localparam int unsigned c_dig_one = 1;
    localparam int unsigned c_dig_neg = 2;
    localparam int unsigned c_dig_w   = 3;

endpackage

`default_nettype wire

// File: rtl/booth_r4_enc.sv
// ============================================================================
// Module      : booth_r4_enc
// Description : Combinational radix-4 Booth recoder, triplet -> {neg, one, two}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0]         triplet,
    output logic [c_dig_w-1:0] digit
);

    // 000 and 111 both recode to zero; neg is never set for a zero digit
    always_comb begin
        digit = '0;
        case (triplet)
            3'b001, 3'b010: begin
                digit[c_dig_one] = 1'b1;
            end
            3'b011: begin
                digit[c_dig_two] = 1'b1;
            end
            3'b100: begin
                digit[c_dig_neg] = 1'b1;
                digit[c_dig_two] = 1'b1;
            end
            3'b101, 3'b110: begin
                digit[c_dig_neg] = 1'b1;
                digit[c_dig_one] = 1'b1;
            end
            default: begin
                digit = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/booth_r4_seq_mult.sv
// ============================================================================
// Module      : booth_r4_seq_mult
// Description : Iterative radix-4 Booth multiplier, one digit per clock,
//               signed/unsigned per operation, valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_r4_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int ITER  = WIDTH / 2 + 1;
    localparam int EXT_W = WIDTH + 2;
    localparam int ACC_W = 2 * WIDTH + 4;
    localparam int CNT_W = $clog2(ITER);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ITER - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [EXT_W:0]       r_mult;
    logic [ACC_W-1:0]     r_mcand;
    logic [ACC_W-1:0]     r_acc;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_sa;
    logic                 w_sb;
    logic [EXT_W-1:0]     w_a_ext;
    logic [ACC_W-1:0]     w_b_ext;
    logic [c_dig_w-1:0]   w_digit;
    logic [ACC_W-1:0]     w_pp;
    logic [ACC_W-1:0]     w_acc_next;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign product   = r_product;
    assign w_accept  = in_valid && (r_state == ST_IDLE);

    // Zero-extension by two bits keeps an unsigned operand positive under Booth recoding
    assign w_sa    = signed_mode & multiplier[WIDTH-1];
    assign w_sb    = signed_mode & multiplicand[WIDTH-1];
    assign w_a_ext = {{2{w_sa}}, multiplier};
    assign w_b_ext = {{(ACC_W - WIDTH){w_sb}}, multiplicand};

    booth_r4_enc u_enc (
        .triplet (r_mult[2:0]),
        .digit   (w_digit)
    );

    // r_mcand is pre-shifted by 4^i, so the partial product is already aligned
    always_comb begin
        w_pp = '0;
        if (w_digit[c_dig_two]) begin
            w_pp = r_mcand << 1;
        end else if (w_digit[c_dig_one]) begin
            w_pp = r_mcand;
        end
        w_acc_next = w_digit[c_dig_neg] ? (r_acc - w_pp) : (r_acc + w_pp);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_mult    <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_mult  <= {w_a_ext, 1'b0};
                r_mcand <= w_b_ext;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (r_state == ST_CALC) begin
                r_mult  <= {2'b00, r_mult[EXT_W:2]};
                r_mcand <= r_mcand << 2;
                r_acc   <= w_acc_next;
                r_cnt   <= r_cnt + c_cnt_one;
                // Product is latched separately so it survives the next accept
                if (r_cnt == c_cnt_last) begin
                    r_product <= w_acc_next[2*WIDTH-1:0];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_booth_r4_seq_mult.sv
// ============================================================================
// Module      : tb_booth_r4_seq_mult
// Description : Directed self-checking bench for the 8- and 16-bit multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_r4_seq_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid8 = 1'b0, in_ready8, sm8 = 1'b0, out_valid8, out_ready8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;

    logic        in_valid16 = 1'b0, in_ready16, sm16 = 1'b0, out_valid16, out_ready16 = 1'b1;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] p16;

    int checks   = 0;
    int failures = 0;

    booth_r4_seq_mult #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid8),
        .in_ready     (in_ready8),
        .signed_mode  (sm8),
        .multiplier   (a8),
        .multiplicand (b8),
        .out_valid    (out_valid8),
        .out_ready    (out_ready8),
        .product      (p8)
    );

    booth_r4_seq_mult #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid16),
        .in_ready     (in_ready16),
        .signed_mode  (sm16),
        .multiplier   (a16),
        .multiplicand (b16),
        .out_valid    (out_valid16),
        .out_ready    (out_ready16),
        .product      (p16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp, input string tag);
        int lat;
        check({tag, " in_ready"}, 32'(in_ready8), 32'd1);
        a8 = a; b8 = b; sm8 = s; in_valid8 = 1'b1; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " product"}, 32'(p8), 32'(exp));
        step();
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [31:0] exp, input string tag);
        int lat;
        a16 = a; b16 = b; sm16 = s; in_valid16 = 1'b1; out_ready16 = 1'b1;
        step();
        in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 40) begin
            step();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd9);
        check({tag, " product"}, p16, exp);
        step();
    endtask

    initial begin
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic [15:0] vp [4];
        logic [15:0] ra, rb;
        logic        rs;
        logic [31:0] re;
        logic        acc;
        int          lat, idx, got, last_t, t;

        va = '{8'd10, 8'd255, 8'd100, 8'd128};
        vb = '{8'd20, 8'd1,   8'd100, 8'd2};
        vp = '{16'h00C8, 16'h00FF, 16'h2710, 16'h0100};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset in_ready", 32'(in_ready8), 32'd1);
        check("reset out_valid", 32'(out_valid8), 32'd0);
        check("reset product", 32'(p8), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Unsigned
        op8(8'd7,   8'd6,   1'b0, 16'h002A, "u 7*6");
        op8(8'd166, 8'd201, 1'b0, 16'h8256, "u 166*201");
        op8(8'd252, 8'd255, 1'b0, 16'hFB04, "u 252*255");

        // Signed, plus same operands unsigned
        op8(8'h88, 8'h54, 1'b1, 16'hD8A0, "s 88*54");
        op8(8'hA6, 8'hC9, 1'b1, 16'h1356, "s A6*C9");
        op8(8'hFC, 8'hFF, 1'b1, 16'h0004, "s FC*FF");
        op8(8'h80, 8'h80, 1'b1, 16'h4000, "s 80*80");
        op8(8'h88, 8'h54, 1'b0, 16'h2CA0, "u 88*54");

        // Backpressure with ignored in_valid during CALC/DONE
        a8 = 8'h0D; b8 = 8'h0B; sm8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
        step();
        a8 = 8'hFF; b8 = 8'hFF; sm8 = 1'b1;
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            step();
            lat++;
        end
        check("bp latency", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            check("bp product", 32'(p8), 32'h008F);
            check("bp out_valid", 32'(out_valid8), 32'd1);
            check("bp in_ready", 32'(in_ready8), 32'd0);
            step();
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        step();
        check("bp after in_ready", 32'(in_ready8), 32'd1);
        check("bp after out_valid", 32'(out_valid8), 32'd0);
        check("bp product held", 32'(p8), 32'h008F);
        step();
        check("bp no spurious accept", 32'(in_ready8), 32'd1);

        // Reset in the middle of CALC
        a8 = 8'h12; b8 = 8'h34; sm8 = 1'b0; in_valid8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", 32'(in_ready8), 32'd1);
        check("midrst out_valid", 32'(out_valid8), 32'd0);
        check("midrst product", 32'(p8), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        op8(8'd3, 8'd5, 1'b0, 16'h000F, "u 3*5 after reset");

        // Back-to-back with in_valid and out_ready held high
        sm8 = 1'b0; out_ready8 = 1'b1; in_valid8 = 1'b1;
        a8 = va[0]; b8 = vb[0];
        idx = 0; got = 0; last_t = 0; t = 0;
        while (got < 4 && t < 100) begin
            acc = in_ready8 && in_valid8;
            if (out_valid8 && out_ready8) begin
                check("b2b product", 32'(p8), 32'(vp[got]));
                if (got > 0) check("b2b spacing", 32'(t - last_t), 32'd7);
                last_t = t;
                got++;
            end
            step();
            t++;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    a8 = va[idx]; b8 = vb[idx];
                end else begin
                    in_valid8 = 1'b0;
                end
            end
        end
        check("b2b count", 32'(got), 32'd4);

        // 16-bit instance: corners then random against the built-in multiply
        op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16 u FFFF*FFFF");
        op16(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "w16 s FFFF*FFFF");
        op16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "w16 s 8000*8000");
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (rs) re = $signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb});
            else    re = {16'b0, ra} * {16'b0, rb};
            op16(ra, rb, rs, re, "w16 random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
